bf16_addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one bf16 add/sub datapath between two requesters. Each requester issues an operand pair and an opcode over a valid/ready handshake. The block grants one request at a time, registers the operands, evaluates them in the shared `bf16_addsub_core`, and returns the result over a per-port response handshake. It sits between the vector front-end lanes and the single FPU adder instance.

---
 rtl/bf16_pkg.sv | 19 +
 rtl/bf16_addsub_arbiter_if.sv | 23 ++
 rtl/bf16_addsub_core.sv | 70 +++++++
 rtl/bf16_addsub_arbiter.sv | 97 +++++++++
 tb/tb_bf16_addsub_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 add/sub arbiter slice.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bf16_addsub_arbiter_if.sv
// Request/response bundle between the two front-end lanes and the shared adder.
interface bf16_addsub_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a0;
    logic [15:0] req_b0;
    logic [15:0] req_a1;
    logic [15:0] req_b1;
    logic [1:0]  req_op;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [15:0] resp_data;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/bf16_addsub_core.sv
// Combinational bf16 add/sub: magnitude ordering, alignment, normalisation, round.
module bf16_addsub_core
    import bf16_pkg::*;
(
    input  bf16_t a,
    input  bf16_t b,
    input  logic  op,
    output bf16_t result
);

    function automatic logic [6:0] round_mant(input logic [7:0] s);
        return s[7:1] + {6'b0, (s[1:0] == 2'b11)};
    endfunction

    // Left shift that puts the leading one of the difference at bit 8.
    function automatic logic [3:0] lead_shift(input logic [8:1] d);
        logic [3:0] sh;
        sh = 4'd8;
        for (int i = 1; i <= 7; i++) begin
            if (d[i]) sh = 4'(8 - i);
        end
        if (d[8]) sh = 4'd0;
        return sh;
    endfunction

    logic       swap, y_zero, sign;
    bf16_t      x, y;
    logic [9:0] sig_x, sig_y, sig_y_sh, sum, diff, norm;
    logic [7:0] ediff, exp_r;
    logic [3:0] sh;
    logic       unused_bits;

    always_comb begin
        swap     = (b[14:0] >= a[14:0]);
        x        = swap ? b : a;
        y        = swap ? a : b;
        sig_x    = {2'b01, x.mant, 1'b0};
        sig_y    = {2'b01, y.mant, 1'b0};
        ediff    = x.exp - y.exp;
        sig_y_sh = sig_y >> ediff;
        y_zero   = (y[14:0] == 15'd0);
        sum      = sig_x + sig_y_sh;
        diff     = sig_x - sig_y_sh;
        sh       = lead_shift(diff[8:1]);
        norm     = diff << sh;
        sign     = x.sign;
        exp_r    = x.exp;
        result   = x;
        if (op == OP_ADD) begin
            if (!y_zero) begin
                if (sum[9]) begin
                    sum   = sum >> 1;
                    exp_r = x.exp + 8'd1;
                end
                result = {x.sign, exp_r, round_mant(sum[7:0])};
            end
        end else begin
            sign = swap ? 1'b1 : x.sign;
            if (y_zero) begin
                result = {sign, x[14:0]};
            end else begin
                exp_r  = x.exp - {4'b0, sh};
                result = {sign, exp_r, round_mant(norm[7:0])};
            end
        end
    end

    assign unused_bits = ^{sum[8], diff[9], diff[0], norm[9:8], y.sign};

endmodule

// File: rtl/bf16_addsub_arbiter.sv
// Round-robin sequencer sharing one bf16 add/sub core between two requesters.
module bf16_addsub_arbiter
    import bf16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bf16_addsub_arbiter_if.slave bus,
    output logic [CNT_W-1:0]     ops_done0,
    output logic [CNT_W-1:0]     ops_done1,
    output logic                 busy
);

    arb_state_t state, state_nx;
    logic       last_grant, gnt, gnt_p0, take, accept;
    logic [1:0] req_ready_c, resp_valid_c;
    logic       op_p0;
    bf16_t      a_p0, b_p0, core_res, res_p1;

    bf16_addsub_core u_core (
        .a      (a_p0),
        .b      (b_p0),
        .op     (op_p0),
        .result (core_res)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Under contention the port that did not win last time is granted.
    always_comb begin
        state_nx     = state;
        gnt          = 1'b0;
        take         = 1'b0;
        accept       = 1'b0;
        req_ready_c  = 2'b00;
        resp_valid_c = 2'b00;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    gnt              = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
                    req_ready_c[gnt] = 1'b1;
                    take             = 1'b1;
                    state_nx         = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                resp_valid_c[gnt_p0] = 1'b1;
                if (bus.resp_ready[gnt_p0]) begin
                    accept   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            gnt_p0     <= 1'b0;
            ops_done0  <= '0;
            ops_done1  <= '0;
        end else begin
            if (take) gnt_p0 <= gnt;
            if (accept) begin
                last_grant <= gnt_p0;
                if (gnt_p0) ops_done1 <= ops_done1 + CNT_W'(1);
                else        ops_done0 <= ops_done0 + CNT_W'(1);
            end
        end
    end

    // p0: issue registers loaded on the request handshake
    always_ff @(posedge clk) begin
        if (take) begin
            a_p0  <= gnt ? bus.req_a1 : bus.req_a0;
            b_p0  <= gnt ? bus.req_b1 : bus.req_b0;
            op_p0 <= bus.req_op[gnt];
        end
    end

    // p1: core result registered during EXEC
    always_ff @(posedge clk) begin
        if (state == EXEC) res_p1 <= core_res;
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = (state == RESP) ? res_p1 : 16'h0000;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_bf16_addsub_arbiter.sv
// Directed bench for the bf16 add/sub arbiter with hand-computed results.
module tb_bf16_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ops0, ops1;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    int          exp_ops0 = 0;
    int          exp_ops1 = 0;

    always #5 clk = ~clk;

    bf16_addsub_arbiter_if bus ();

    bf16_addsub_arbiter #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ops_done0 (ops0),
        .ops_done1 (ops1),
        .busy      (busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.req_valid  = 2'b00;
        bus.req_a0     = 16'h0;
        bus.req_b0     = 16'h0;
        bus.req_a1     = 16'h0;
        bus.req_b1     = 16'h0;
        bus.req_op     = 2'b00;
        bus.resp_ready = 2'b11;
    endtask

    // Drives one request on port p; returns the result and handshake-to-response latency.
    task automatic run_op(input int p, input logic [15:0] a, input logic [15:0] b, input logic op,
                          output logic [15:0] res, output int lat, output logic ok);
        @(negedge clk);
        if (p == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
        else        begin bus.req_a1 = a; bus.req_b1 = b; end
        bus.req_op[p]    = op;
        bus.req_valid[p] = 1'b1;
        ok  = 1'b0;
        res = 16'hxxxx;
        lat = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.req_ready[p]) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_valid[p] = 1'b0;
        if (ok) begin
            ok  = 1'b0;
            lat = 1;
            for (int i = 0; i < 20 && !ok; i++) begin
                if (bus.resp_valid[p]) begin
                    ok  = 1'b1;
                    res = bus.resp_data;
                end else begin
                    @(negedge clk);
                    lat++;
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ops0 = 0;
        exp_ops1 = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
        checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b exp 00", bus.resp_valid); end
        checks++; if (bus.resp_data !== 16'h0000) begin errors++; $display("FAIL reset_resp_data got %h exp 0000", bus.resp_data); end
        checks++; if (ops0 !== 16'd0 || ops1 !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d/%0d exp 0/0", ops0, ops1); end
    endtask

    task automatic test_port0();
        logic [15:0] res; int lat; logic ok;
        run_op(0, 16'h3F80, 16'h3F80, 1'b1, res, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL p0_timeout got no response exp response"); end
        checks++; if (res !== 16'h4000) begin errors++; $display("FAIL p0_add got %h exp 4000", res); end
        checks++; if (lat != 2) begin errors++; $display("FAIL p0_latency got %0d exp 2", lat); end
        checks++; if (bus.resp_valid !== 2'b01) begin errors++; $display("FAIL p0_resp_valid got %b exp 01", bus.resp_valid); end
        @(negedge clk);
        exp_ops0++;
        checks++; if (ops0 !== 16'(exp_ops0)) begin errors++; $display("FAIL p0_ops_done got %0d exp %0d", ops0, exp_ops0); end
    endtask

    task automatic test_port1();
        logic [15:0] res; int lat; logic ok;
        run_op(1, 16'h4000, 16'h3F80, 1'b0, res, lat, ok);
        exp_ops1++;
        checks++; if (!ok || res !== 16'h3F80) begin errors++; $display("FAIL p1_sub got %h exp 3f80", res); end
        checks++; if (bus.resp_valid !== 2'b10) begin errors++; $display("FAIL p1_resp_valid got %b exp 10", bus.resp_valid); end
        run_op(1, 16'h3F00, 16'h0000, 1'b1, res, lat, ok);
        exp_ops1++;
        checks++; if (!ok || res !== 16'h3F00) begin errors++; $display("FAIL p1_add_zero got %h exp 3f00", res); end
        @(negedge clk);
        checks++; if (ops1 !== 16'(exp_ops1) || ops0 !== 16'(exp_ops0)) begin
            errors++; $display("FAIL p1_ops_done got %0d/%0d exp %0d/%0d", ops0, ops1, exp_ops0, exp_ops1);
        end
    endtask

    task automatic test_arith();
        logic [15:0] res; int lat; logic ok;
        run_op(0, 16'h3F80, 16'h3F00, 1'b1, res, lat, ok);
        exp_ops0++;
        checks++; if (!ok || res !== 16'h3FC0) begin errors++; $display("FAIL add_align got %h exp 3fc0", res); end
        run_op(0, 16'h3F80, 16'h3F03, 1'b1, res, lat, ok);
        exp_ops0++;
        checks++; if (!ok || res !== 16'h3FC2) begin errors++; $display("FAIL add_round got %h exp 3fc2", res); end
        run_op(0, 16'h3F80, 16'h4000, 1'b0, res, lat, ok);
        exp_ops0++;
        checks++; if (!ok || res !== 16'hBF80) begin errors++; $display("FAIL sub_swap got %h exp bf80", res); end
        @(negedge clk);
        checks++; if (ops0 !== 16'(exp_ops0)) begin errors++; $display("FAIL arith_ops_done got %0d exp %0d", ops0, exp_ops0); end
    endtask

    task automatic test_backpressure();
        logic [15:0] res; int lat; logic ok;
        bus.resp_ready = 2'b10;
        run_op(0, 16'h3F80, 16'h3F00, 1'b1, res, lat, ok);
        checks++; if (!ok || res !== 16'h3FC0) begin errors++; $display("FAIL bp_first got %h exp 3fc0", res); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 2'b01 || bus.resp_data !== 16'h3FC0 || bus.req_ready !== 2'b00 ||
                ops0 !== 16'(exp_ops0) || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid %b data %h ready %b ops %0d exp 01 3fc0 00 %0d",
                         i, bus.resp_valid, bus.resp_data, bus.req_ready, ops0, exp_ops0);
            end
        end
        bus.resp_ready = 2'b11;
        @(negedge clk);
        exp_ops0++;
        checks++; if (ops0 !== 16'(exp_ops0) || busy !== 1'b0 || bus.resp_valid !== 2'b00) begin
            errors++; $display("FAIL bp_release got ops %0d busy %b valid %b exp %0d 0 00", ops0, busy, bus.resp_valid, exp_ops0);
        end
    endtask

    task automatic test_back_to_back();
        int grants[$];
        int nresp = 0;
        logic [15:0] exp_d;
        @(negedge clk);
        bus.req_a0 = 16'h3F80; bus.req_b0 = 16'h3F80; bus.req_op[0] = 1'b1;
        bus.req_a1 = 16'h4000; bus.req_b1 = 16'h3F80; bus.req_op[1] = 1'b0;
        bus.req_valid = 2'b11;
        for (int cyc = 0; cyc < 100 && nresp < 8; cyc++) begin
            #1;
            if (bus.req_ready == 2'b01) grants.push_back(0);
            else if (bus.req_ready == 2'b10) grants.push_back(1);
            else if (bus.req_ready == 2'b11) grants.push_back(9);
            if (bus.resp_valid != 2'b00) begin
                nresp++;
                exp_d = bus.resp_valid[1] ? 16'h3F80 : 16'h4000;
                checks++;
                if (bus.resp_valid == 2'b11 || bus.resp_data !== exp_d) begin
                    errors++; $display("FAIL b2b_resp got valid %b data %h exp one-hot %h", bus.resp_valid, bus.resp_data, exp_d);
                end
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        exp_ops0 += 4;
        exp_ops1 += 4;
        checks++; if (grants.size() != 8) begin errors++; $display("FAIL b2b_grant_count got %0d exp 8", grants.size()); end
        for (int i = 0; i < grants.size() && i < 8; i++) begin
            checks++;
            if (grants[i] != (i % 2)) begin errors++; $display("FAIL b2b_order idx %0d got %0d exp %0d", i, grants[i], i % 2); end
        end
        checks++; if (ops0 !== 16'(exp_ops0) || ops1 !== 16'(exp_ops1)) begin
            errors++; $display("FAIL b2b_ops_done got %0d/%0d exp %0d/%0d", ops0, ops1, exp_ops0, exp_ops1);
        end
    endtask

    task automatic test_reset_exec();
        logic [15:0] res; int lat; logic ok;
        run_op(0, 16'h3F80, 16'h3F80, 1'b1, res, lat, ok);
        exp_ops0++;
        @(negedge clk);
        bus.req_a1 = 16'h4000; bus.req_b1 = 16'h3F80; bus.req_op[1] = 1'b1;
        bus.req_valid = 2'b10;
        @(negedge clk);
        bus.req_valid = 2'b00;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rx_in_exec got busy %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00) begin
            errors++; $display("FAIL rx_idle got busy %b valid %b exp 0 00", busy, bus.resp_valid);
        end
        exp_ops0 = 0;
        exp_ops1 = 0;
        checks++; if (ops0 !== 16'd0 || ops1 !== 16'd0) begin errors++; $display("FAIL rx_ops got %0d/%0d exp 0/0", ops0, ops1); end
        @(negedge clk);
        checks++; if (bus.resp_valid !== 2'b00) begin errors++; $display("FAIL rx_no_resp got %b exp 00", bus.resp_valid); end
        bus.req_a0 = 16'h3F80; bus.req_b0 = 16'h3F80; bus.req_op[0] = 1'b1;
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rx_next_grant got %b exp 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 16'h4000) begin
            errors++; $display("FAIL rx_after_resp got %b %h exp 01 4000", bus.resp_valid, bus.resp_data);
        end
        @(negedge clk);
        exp_ops0++;
        checks++; if (ops0 !== 16'(exp_ops0) || ops1 !== 16'(exp_ops1)) begin
            errors++; $display("FAIL rx_final_ops got %0d/%0d exp %0d/%0d", ops0, ops1, exp_ops0, exp_ops1);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_port0();
        test_port1();
        test_arith();
        test_backpressure();
        test_reset();
        test_back_to_back();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
